enemy_spawn_scheduler: RTL



---
 rtl/enemy_spawn_scheduler_if.sv | 21 ++
 rtl/enemy_spawn_scheduler.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/enemy_spawn_scheduler_if.sv
// Spawn scheduler bundle: frame/game inputs toward the scheduler,
// spawn request, applied interval and defer pulse back out.
interface enemy_spawn_scheduler_if;
  logic       frame_tick;
  logic       run;
  logic [7:0] enemy_active;
  logic [6:0] score;
  logic [7:0] spawn_tick;
  logic [7:0] interval;
  logic       defer;

  modport master (
    output frame_tick, run, enemy_active, score,
    input  spawn_tick, interval, defer
  );

  modport slave (
    input  frame_tick, run, enemy_active, score,
    output spawn_tick, interval, defer
  );
endinterface

// File: rtl/enemy_spawn_scheduler.sv
// Per-frame enemy spawner: LFSR lane pick, round-robin busy skip, cap.
// Define SPAWN_RAMP_EN to shorten the interval as score rises.
module enemy_spawn_scheduler #(
  parameter int          BASE_INTERVAL = 90,
  parameter int          MIN_INTERVAL  = 20,
  parameter int          RAMP_STEP     = 10,
  parameter int          SCORE_SHIFT   = 3,
  parameter int          MAX_ACTIVE    = 4,
  parameter int          FIRST_DELAY   = 30,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input logic                    clk,
  input logic                    rst,
  enemy_spawn_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT,
    PICK,
    PROBE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  lane_q, lane_d;
  logic [2:0]  probe_q, probe_d;
  logic [7:0]  spawn_q, spawn_d;
  logic        defer_q, defer_d;
  logic        strb_q;
  logic [7:0]  interval_q, interval_d;
  logic [3:0]  active_cnt;
  logic        fb;

`ifdef SPAWN_RAMP_EN
  localparam logic [15:0] SPAN = 16'(BASE_INTERVAL - MIN_INTERVAL);
  logic [15:0] dec;

  // Wide product so the clamp compare never sees a wrapped value.
  assign dec = 16'(bus.score >> SCORE_SHIFT) * 16'(RAMP_STEP);

  always_comb begin
    interval_d = 8'(BASE_INTERVAL);
    if (dec >= SPAN)
      interval_d = 8'(MIN_INTERVAL);
    else
      interval_d = 8'(16'(BASE_INTERVAL) - dec);
  end
`else
  always_comb begin
    interval_d = 8'(BASE_INTERVAL);
  end
`endif

  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= WAIT;
      cnt_q      <= 8'(FIRST_DELAY);
      lfsr_q     <= SEED;
      lane_q     <= 3'd0;
      probe_q    <= 3'd0;
      spawn_q    <= 8'd0;
      defer_q    <= 1'b0;
      strb_q     <= 1'b0;
      interval_q <= 8'(BASE_INTERVAL);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      lane_q     <= lane_d;
      probe_q    <= probe_d;
      spawn_q    <= spawn_d;
      defer_q    <= defer_d;
      strb_q     <= bus.frame_tick;
      interval_q <= interval_d;
    end
  end

  always_comb begin
    active_cnt = 4'd0;
    for (int i = 0; i < 8; i++)
      active_cnt = active_cnt + {3'd0, bus.enemy_active[i]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    lane_d  = lane_q;
    probe_d = probe_q;
    spawn_d = spawn_q;
    defer_d = 1'b0;
    unique case (state_q)
      WAIT: begin
        if (strb_q) begin
          spawn_d = 8'd0;
          if (bus.run) begin
            if (cnt_q == 8'd0)
              state_d = PICK;
            else
              cnt_d = cnt_q - 8'd1;
          end
        end
      end
      PICK: begin
        // At the cap: cnt stays 0 so every later strobe retries.
        if (active_cnt >= 4'(MAX_ACTIVE)) begin
          defer_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = WAIT;
        end else begin
          lane_d  = lfsr_q[2:0];
          lfsr_d  = {lfsr_q[14:0], fb};
          probe_d = 3'd0;
          state_d = PROBE;
        end
      end
      PROBE: begin
        if (!bus.enemy_active[lane_q]) begin
          spawn_d = 8'd1 << lane_q;
          cnt_d   = interval_q - 8'd1;
          state_d = WAIT;
        end else if (probe_q == 3'd7) begin
          defer_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = WAIT;
        end else begin
          lane_d  = lane_q + 3'd1;
          probe_d = probe_q + 3'd1;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  assign bus.spawn_tick = spawn_q;
  assign bus.interval   = interval_q;
  assign bus.defer      = defer_q;

endmodule
